// File: rtl/regfile_scoreboard.sv
// Register file, 2 async read / 1 write, with a per-register busy scoreboard for RAW hazard detection.
// Reads are zero-latency; writes, reserves and busy_count update at the edge. There is no backpressure.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
    input  logic                  ctrl_flush,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [ADDR_WIDTH:0]   busy_count
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_next;
    logic [ADDR_WIDTH:0]   r_busy_count;
    logic [ADDR_WIDTH:0]   w_pop;
    logic                  w_wr_ok;
    logic                  w_rsv_ok;
    logic                  w_zero_a;
    logic                  w_zero_b;
    logic                  w_hit_a;
    logic                  w_hit_b;

    assign w_wr_ok  = ctrl_writeEnable   && !(ZERO_REG && (ctrl_writeReg   == '0));
    assign w_rsv_ok = ctrl_reserveEnable && !(ZERO_REG && (ctrl_reserveReg == '0));

    // Writeback clears first so a same-cycle reserve (the newer producer) wins; flush beats both.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok) begin
            w_busy_next[ctrl_writeReg] = 1'b0;
        end
        if (ctrl_flush) begin
            w_busy_next = '0;
        end else if (w_rsv_ok) begin
            w_busy_next[ctrl_reserveReg] = 1'b1;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pop = w_pop + {{ADDR_WIDTH{1'b0}}, w_busy_next[i]};
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[ctrl_writeReg] <= data_writeReg;
            end
            r_busy       <= w_busy_next;
            r_busy_count <= w_pop;
        end
    end

    assign w_zero_a = ZERO_REG && (ctrl_readRegA == '0);
    assign w_zero_b = ZERO_REG && (ctrl_readRegB == '0);
    assign w_hit_a  = BYPASS && w_wr_ok && (ctrl_writeReg == ctrl_readRegA);
    assign w_hit_b  = BYPASS && w_wr_ok && (ctrl_writeReg == ctrl_readRegB);

    assign data_readRegA = w_zero_a ? '0 : (w_hit_a ? data_writeReg : r_regs[ctrl_readRegA]);
    assign data_readRegB = w_zero_b ? '0 : (w_hit_b ? data_writeReg : r_regs[ctrl_readRegB]);
    assign busy_readRegA = !w_zero_a && !w_hit_a && r_busy[ctrl_readRegA];
    assign busy_readRegB = !w_zero_b && !w_hit_b && r_busy[ctrl_readRegB];
    assign busy_count    = r_busy_count;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share stimulus and a reference model.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic          ctrl_reserveEnable;
    logic [AW-1:0] ctrl_reserveReg;
    logic          ctrl_flush;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;

    logic [DW-1:0] y_data_a, y_data_b, n_data_a, n_data_b;
    logic          y_busy_a, y_busy_b, n_busy_a, n_busy_b;
    logic [AW:0]   y_cnt, n_cnt;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg), .ctrl_flush(ctrl_flush),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(y_data_a), .data_readRegB(y_data_b),
        .busy_readRegA(y_busy_a), .busy_readRegB(y_busy_b), .busy_count(y_cnt)
    );

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_reserveEnable(ctrl_reserveEnable), .ctrl_reserveReg(ctrl_reserveReg), .ctrl_flush(ctrl_flush),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(n_data_a), .data_readRegB(n_data_b),
        .busy_readRegA(n_busy_a), .busy_readRegB(n_busy_b), .busy_count(n_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected read data: register 0 is always zero, a bypassing port sees this cycle's write.
    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
        return m_regs[a];
    endfunction

    function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && ctrl_writeEnable && ctrl_writeReg == a) return '0;
        return {31'b0, m_busy[a]};
    endfunction

    function automatic logic [DW-1:0] model_count();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return DW'(c);
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_reads();
        chk("rdA_byp",   y_data_a,           exp_data(ctrl_readRegA, 1'b1));
        chk("rdB_byp",   y_data_b,           exp_data(ctrl_readRegB, 1'b1));
        chk("bsyA_byp",  {31'b0, y_busy_a},  exp_busy(ctrl_readRegA, 1'b1));
        chk("bsyB_byp",  {31'b0, y_busy_b},  exp_busy(ctrl_readRegB, 1'b1));
        chk("rdA_nbyp",  n_data_a,           exp_data(ctrl_readRegA, 1'b0));
        chk("rdB_nbyp",  n_data_b,           exp_data(ctrl_readRegB, 1'b0));
        chk("bsyA_nbyp", {31'b0, n_busy_a},  exp_busy(ctrl_readRegA, 1'b0));
        chk("bsyB_nbyp", {31'b0, n_busy_b},  exp_busy(ctrl_readRegB, 1'b0));
    endtask

    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic fl,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        @(negedge clock);
        ctrl_writeEnable   = we;
        ctrl_writeReg      = wa;
        data_writeReg      = wd;
        ctrl_reserveEnable = re;
        ctrl_reserveReg    = ra;
        ctrl_flush         = fl;
        ctrl_readRegA      = a;
        ctrl_readRegB      = b;
        #1;
        check_reads();
        @(posedge clock);
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (fl) foreach (m_busy[i]) m_busy[i] = 1'b0;
        else if (re && ra != 0) m_busy[ra] = 1'b1;
        #1;
        chk("cnt_byp",  {26'b0, y_cnt}, model_count());
        chk("cnt_nbyp", {26'b0, n_cnt}, model_count());
    endtask

    task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, a, b);
    endtask

    initial begin
        ctrl_reset_n       = 1'b0;
        ctrl_writeEnable   = 1'b0;
        ctrl_writeReg      = '0;
        data_writeReg      = '0;
        ctrl_reserveEnable = 1'b0;
        ctrl_reserveReg    = '0;
        ctrl_flush         = 1'b0;
        ctrl_readRegA      = 5'd5;
        ctrl_readRegB      = 5'd31;
        model_reset();
        #12;
        chk("rst_cnt",  {26'b0, y_cnt}, '0);
        chk("rst_rdA",  y_data_a, '0);
        chk("rst_bsyA", {31'b0, y_busy_a}, '0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        // Write r5 with a same-cycle read; the non-bypass copy sees it one cycle later.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        chk("nb_r5_next", n_data_a, 32'hDEADBEEF);

        // Register 0 ignores writes and reserves.
        cycle(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("zero_cnt", {26'b0, y_cnt}, '0);

        // Reserve r3, then write it back with the busy bit forwarded clear.
        cycle(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);
        chk("r3_busy", {31'b0, y_busy_a}, 32'd1);
        chk("r3_cnt",  {26'b0, y_cnt}, 32'd1);
        cycle(1'b1, 5'd3, 32'h0BADF00D, 1'b0, '0, 1'b0, 5'd3, 5'd3);
        chk("r3_clr_cnt", {26'b0, y_cnt}, '0);

        // Reserve and write r7 together: the reserve wins.
        cycle(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b0, 5'd7, 5'd3);
        idle(5'd7, 5'd7);
        chk("r7_busy", {31'b0, y_busy_a}, 32'd1);
        chk("r7_data", y_data_a, 32'hA5A5A5A5);

        // Fill the scoreboard, then flush with a competing reserve.
        for (int r = 1; r < NR; r++) cycle(1'b0, '0, '0, 1'b1, AW'(r), 1'b0, AW'(r), 5'd7);
        chk("cnt31", {26'b0, y_cnt}, 32'd31);
        cycle(1'b0, '0, '0, 1'b1, 5'd2, 1'b1, 5'd5, 5'd7);
        chk("flush_cnt", {26'b0, y_cnt}, '0);
        idle(5'd5, 5'd7);

        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0) ? ctrl_writeReg : AW'($urandom), AW'($urandom));
        end

        // Load a known state of three busy registers, then drop reset between edges.
        cycle(1'b1, 5'd1, 32'h11111111, 1'b0, '0, 1'b1, 5'd1, 5'd2);
        cycle(1'b1, 5'd2, 32'h22222222, 1'b1, 5'd1, 1'b0, 5'd1, 5'd2);
        cycle(1'b0, '0, '0, 1'b1, 5'd2, 1'b0, 5'd1, 5'd2);
        cycle(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, 5'd1, 5'd2);
        chk("pre_rst_cnt", {26'b0, y_cnt}, 32'd3);
        @(negedge clock);
        ctrl_reserveEnable = 1'b0;
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_rdA",  y_data_a, '0);
        chk("mid_rst_rdB",  y_data_b, '0);
        chk("mid_rst_bsyA", {31'b0, y_busy_a}, '0);
        chk("mid_rst_cnt",  {26'b0, y_cnt}, '0);
        chk("mid_rst_cntn", {26'b0, n_cnt}, '0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        idle(5'd1, 5'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
